// File: rtl/hyperbus_pkg.sv
// Shared types, constants and the round-robin helper for the hyperbus
// arbiter and its pointer sub-module.
package hyperbus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_XFER = 3'b010,
        ST_GAP  = 3'b100
    } state_e;

    localparam int         MAX_PORTS = 4;
    localparam logic [7:0] MASK_ALL  = 8'hFF;

    // Offsets 1..nports from last; offset nports is last itself, so the
    // previous winner gets the lowest priority. Returns last when nothing
    // is requested; callers gate with their own "any request" flag.
    function automatic logic [1:0] rr_next(
        input logic [MAX_PORTS-1:0] req,
        input logic [1:0]           last,
        input int                   nports
    );
        logic [1:0] pick;
        int         idx;
        pick = last;
        for (int k = MAX_PORTS; k >= 1; k--) begin
            if (k <= nports) begin
                idx = (int'(last) + k) % nports;
                if (req[idx[1:0]]) begin
                    pick = idx[1:0];
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/hyperbus_rr_arb.sv
// Combinational round-robin picker with a registered last-grant pointer.
// The pointer resets to the highest port so port 0 wins the first pick.
module hyperbus_rr_arb
    import hyperbus_pkg::*;
#(
    parameter int NPORTS = 2
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NPORTS-1:0]                     req_i,
    input  logic                                  take_i,
    output logic [((NPORTS > 1) ? $clog2(NPORTS) : 1)-1:0] gnt_idx_o,
    output logic                                  gnt_vld_o
);

    localparam int IDX_W = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    logic [MAX_PORTS-1:0] req_pad;
    logic [IDX_W-1:0]     last_q;
    logic [IDX_W-1:0]     last_d;

    always_comb begin
        req_pad              = '0;
        req_pad[NPORTS-1:0]  = req_i;
        gnt_vld_o            = |req_i;
        gnt_idx_o            = IDX_W'(rr_next(req_pad, 2'(last_q), NPORTS));
        last_d               = last_q;
        if (take_i) begin
            last_d = gnt_idx_o;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= IDX_W'(NPORTS - 1);
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/hyperbus_arbiter.sv
// Shares one hyperbus leader controller between NPORTS burst requesters:
// round-robin grant, wrq/rrq handshake, word counting, gap and timeout.
module hyperbus_arbiter
    import hyperbus_pkg::*;
#(
    parameter int NPORTS      = 2,
    parameter int ADDR_LENGTH = 32,
    parameter int DATA_W      = 16,
    parameter int LEN_W       = 8,
    parameter int GAP_CYCLES  = 4,
    parameter int TIMEOUT     = 1023
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NPORTS-1:0]               req_i,
    input  logic [NPORTS-1:0]               we_i,
    input  logic [NPORTS-1:0]               regsp_i,
    input  logic [NPORTS*ADDR_LENGTH-1:0]   adr_i,
    input  logic [NPORTS*LEN_W-1:0]         len_i,
    output logic [NPORTS-1:0]               ack_o,
    input  logic [NPORTS*DATA_W-1:0]        wdat_i,
    input  logic [NPORTS*(DATA_W/8)-1:0]    wmask_i,
    output logic [NPORTS-1:0]               wrdy_o,
    output logic [DATA_W-1:0]               rdat_o,
    output logic [NPORTS-1:0]               rvld_o,
    output logic [NPORTS-1:0]               done_o,
    output logic [NPORTS-1:0]               err_o,
    output logic [ADDR_LENGTH-1:0]          hb_adr_o,
    output logic [DATA_W-1:0]               hb_dat_o,
    output logic [DATA_W/8-1:0]             hb_mask_o,
    output logic                            hb_regsp_o,
    output logic                            hb_wrq_o,
    output logic                            hb_rrq_o,
    input  logic                            hb_ready_i,
    input  logic                            hb_valid_i,
    input  logic [DATA_W-1:0]               hb_dat_i
);

    localparam int IDX_W  = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam int MASK_W = DATA_W / 8;
    localparam int TMR_W  = $clog2(TIMEOUT + 1);
    localparam int GAP_W  = $clog2(GAP_CYCLES + 1);

    logic [IDX_W-1:0] arb_idx;
    logic             arb_vld;
    logic             arb_take;

    hyperbus_rr_arb #(
        .NPORTS (NPORTS)
    ) u_rr_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (req_i),
        .take_i    (arb_take),
        .gnt_idx_o (arb_idx),
        .gnt_vld_o (arb_vld)
    );

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        gnt_q, gnt_d;
    logic [ADDR_LENGTH-1:0]  adr_q, adr_d;
    logic                    we_q, we_d;
    logic                    regsp_q, regsp_d;
    logic [LEN_W:0]          len_q, len_d;
    logic [LEN_W:0]          cnt_q, cnt_d;
    logic [TMR_W-1:0]        timer_q, timer_d;
    logic [GAP_W-1:0]        gap_q, gap_d;
    logic                    wrq_q, wrq_d;
    logic                    rrq_q, rrq_d;
    logic [NPORTS-1:0]       ack_q, ack_d;
    logic [NPORTS-1:0]       done_q, done_d;
    logic [NPORTS-1:0]       err_q, err_d;
    logic [NPORTS-1:0]       rvld_q, rvld_d;
    logic [DATA_W-1:0]       rdat_q, rdat_d;

    logic [LEN_W-1:0]        len_raw;
    logic [LEN_W:0]          len_sel;
    logic [LEN_W:0]          cnt_inc;
    logic                    wr_active;
    logic                    wr_fire;
    logic                    rd_fire;
    logic                    fire;
    logic                    last_word;

    // A word only counts while the request is up and the burst is short
    // of its length; ready/valid overrun after the last word is ignored.
    always_comb begin
        len_raw   = len_i[arb_idx*LEN_W +: LEN_W];
        len_sel   = (len_raw == '0) ? (LEN_W+1)'(1) : {1'b0, len_raw};
        wr_active = (state_q == ST_XFER) && wrq_q && (cnt_q < len_q);
        wr_fire   = wr_active && hb_ready_i;
        rd_fire   = (state_q == ST_XFER) && rrq_q && hb_valid_i && (cnt_q < len_q);
        fire      = wr_fire || rd_fire;
        cnt_inc   = cnt_q + 1'b1;
        last_word = fire && (cnt_inc == len_q);
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        adr_d    = adr_q;
        we_d     = we_q;
        regsp_d  = regsp_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        timer_d  = timer_q;
        gap_d    = gap_q;
        wrq_d    = wrq_q;
        rrq_d    = rrq_q;
        rdat_d   = rdat_q;
        ack_d    = '0;
        done_d   = '0;
        err_d    = '0;
        rvld_d   = '0;
        arb_take = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (arb_vld) begin
                    arb_take       = 1'b1;
                    gnt_d          = arb_idx;
                    adr_d          = adr_i[arb_idx*ADDR_LENGTH +: ADDR_LENGTH];
                    we_d           = we_i[arb_idx];
                    regsp_d        = regsp_i[arb_idx];
                    len_d          = len_sel;
                    cnt_d          = '0;
                    timer_d        = '0;
                    ack_d[arb_idx] = 1'b1;
                    state_d        = ST_XFER;
                end
            end

            ST_XFER: begin
                // First XFER cycle is the ack cycle; the request rises after it.
                if (ack_q != '0) begin
                    wrq_d = we_q;
                    rrq_d = !we_q;
                end else if (fire) begin
                    cnt_d   = cnt_inc;
                    timer_d = '0;
                    if (rd_fire) begin
                        rvld_d[gnt_q] = 1'b1;
                        rdat_d        = hb_dat_i;
                    end
                    if (last_word) begin
                        wrq_d         = 1'b0;
                        rrq_d         = 1'b0;
                        done_d[gnt_q] = 1'b1;
                        gap_d         = '0;
                        state_d       = ST_GAP;
                    end
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    wrq_d         = 1'b0;
                    rrq_d         = 1'b0;
                    done_d[gnt_q] = 1'b1;
                    err_d[gnt_q]  = 1'b1;
                    gap_d         = '0;
                    state_d       = ST_GAP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            ST_GAP: begin
                if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                wrq_d   = 1'b0;
                rrq_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            adr_q   <= '0;
            we_q    <= 1'b0;
            regsp_q <= 1'b0;
            len_q   <= '0;
            cnt_q   <= '0;
            timer_q <= '0;
            gap_q   <= '0;
            wrq_q   <= 1'b0;
            rrq_q   <= 1'b0;
            ack_q   <= '0;
            done_q  <= '0;
            err_q   <= '0;
            rvld_q  <= '0;
            rdat_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            adr_q   <= adr_d;
            we_q    <= we_d;
            regsp_q <= regsp_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
            gap_q   <= gap_d;
            wrq_q   <= wrq_d;
            rrq_q   <= rrq_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rvld_q  <= rvld_d;
            rdat_q  <= rdat_d;
        end
    end

    // Write data path is combinational so the controller sees the granted
    // port's word in the same cycle it asserts ready.
    always_comb begin
        hb_dat_o  = '0;
        hb_mask_o = MASK_W'(MASK_ALL);
        wrdy_o    = '0;
        if (wr_active) begin
            hb_dat_o      = wdat_i[gnt_q*DATA_W +: DATA_W];
            hb_mask_o     = wmask_i[gnt_q*MASK_W +: MASK_W];
            wrdy_o[gnt_q] = hb_ready_i;
        end
    end

    assign ack_o      = ack_q;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign rvld_o     = rvld_q;
    assign rdat_o     = rdat_q;
    assign hb_adr_o   = adr_q;
    assign hb_regsp_o = regsp_q;
    assign hb_wrq_o   = wrq_q;
    assign hb_rrq_o   = rrq_q;

endmodule
